// File: rtl/scr_test_sequencer.sv
// Sequencer for one SCR breakdown/BOD test run. It drives alternating trigger pulses
// and the forbid level to the breakdown detector, and counts faults per polarity.
module scr_test_sequencer #(
    parameter int unsigned PULSE_W    = 500,
    parameter int unsigned HALF_P     = 500000,
    parameter int unsigned SETTLE     = 50000,
    parameter int unsigned TAIL       = 900100,
    parameter int unsigned N_CYC      = 16,
    parameter int unsigned FAIL_LIMIT = 3
) (
    input  logic       i_clk_50m,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_fwd_state,
    input  logic       i_neg_state,
    input  logic       i_fwd_bod,
    input  logic       i_neg_bod,
    output logic       o_trig_fwd,
    output logic       o_trig_neg,
    output logic       o_forbid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_fwd_fault,
    output logic [7:0] o_neg_fault,
    output logic [1:0] o_bod_seen
);

    localparam logic [19:0] PC_PULSE      = 20'(PULSE_W);
    localparam logic [19:0] PC_HALF_END   = 20'(HALF_P - 1);
    localparam logic [19:0] PC_SETTLE_END = 20'(SETTLE - 1);
    localparam logic [19:0] PC_TAIL_END   = 20'(TAIL - 1);
    localparam logic [19:0] PC_SAMPLE     = 20'd4;
    localparam logic [7:0]  K_LAST        = 8'(N_CYC);
    localparam logic [8:0]  LIMIT         = 9'(FAIL_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FWD,
        ST_NEG,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] pc_q, pc_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  fwd_fault_q, fwd_fault_d;
    logic [7:0]  neg_fault_q, neg_fault_d;
    logic [1:0]  bod_seen_q, bod_seen_d;
    logic        pass_q, pass_d;
    logic        armed_q, armed_d;
    logic        sample_fwd;
    logic        sample_neg;
    logic        enter_done;

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            k_q         <= '0;
            fwd_fault_q <= '0;
            neg_fault_q <= '0;
            bod_seen_q  <= '0;
            pass_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            k_q         <= k_d;
            fwd_fault_q <= fwd_fault_d;
            neg_fault_q <= neg_fault_d;
            bod_seen_q  <= bod_seen_d;
            pass_q      <= pass_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q + 20'd1;
        k_d         = k_q;
        fwd_fault_d = fwd_fault_q;
        neg_fault_d = neg_fault_q;
        bod_seen_d  = bod_seen_q;
        pass_d      = pass_q;
        armed_d     = armed_q;
        sample_fwd  = 1'b0;
        sample_neg  = 1'b0;
        enter_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                // A start is only taken once i_start has been seen low in IDLE
                if (!i_start) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d     = 1'b0;
                    fwd_fault_d = '0;
                    neg_fault_d = '0;
                    bod_seen_d  = '0;
                    pass_d      = 1'b0;
                    k_d         = 8'd1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (pc_q == PC_SETTLE_END) begin
                    pc_d    = '0;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                sample_neg = (pc_q == PC_SAMPLE) && (k_q > 8'd1);
                if (pc_q == PC_HALF_END) begin
                    pc_d    = '0;
                    state_d = ST_NEG;
                end
            end
            ST_NEG: begin
                sample_fwd = (pc_q == PC_SAMPLE);
                if (k_q < K_LAST) begin
                    if (pc_q == PC_HALF_END) begin
                        pc_d    = '0;
                        k_d     = k_q + 8'd1;
                        state_d = ST_FWD;
                    end
                end else if (pc_q == PC_TAIL_END) begin
                    // The long tail lets the detector time out before the last negative sample
                    sample_neg = 1'b1;
                    enter_done = 1'b1;
                    pc_d       = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (sample_neg) begin
            if (!i_fwd_state && (neg_fault_q != 8'hFF)) neg_fault_d = neg_fault_q + 8'd1;
            if (i_neg_bod) bod_seen_d[0] = 1'b1;
        end
        if (sample_fwd) begin
            if (!i_neg_state && (fwd_fault_q != 8'hFF)) fwd_fault_d = fwd_fault_q + 8'd1;
            if (i_fwd_bod) bod_seen_d[1] = 1'b1;
        end
        if (enter_done) begin
            pass_d = ({1'b0, fwd_fault_d} + {1'b0, neg_fault_d}) <= LIMIT;
        end

        if (i_abort) begin
            state_d     = ST_IDLE;
            pc_d        = '0;
            k_d         = '0;
            fwd_fault_d = '0;
            neg_fault_d = '0;
            bod_seen_d  = '0;
            pass_d      = 1'b0;
            armed_d     = 1'b0;
        end
    end

    // Outputs decode from registered state so an async reset drops the triggers at once
    assign o_trig_fwd  = (state_q == ST_FWD) && (pc_q < PC_PULSE);
    assign o_trig_neg  = (state_q == ST_NEG) && (pc_q < PC_PULSE);
    assign o_forbid    = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign o_busy      = (state_q == ST_SETTLE) || (state_q == ST_FWD) || (state_q == ST_NEG);
    assign o_done      = (state_q == ST_DONE);
    assign o_pass      = pass_q;
    assign o_fwd_fault = fwd_fault_q;
    assign o_neg_fault = neg_fault_q;
    assign o_bod_seen  = bod_seen_q;

endmodule

// File: tb/tb_scr_test_sequencer.sv
// Directed testbench for scr_test_sequencer, run with shortened timing parameters
// so that a complete run (1+SETTLE+7*HALF_P+TAIL = 181 cycles) stays small.
module tb_scr_test_sequencer;

    localparam int PULSE_W    = 5;
    localparam int HALF_P     = 20;
    localparam int SETTLE     = 10;
    localparam int TAIL       = 30;
    localparam int N_CYC      = 4;
    localparam int FAIL_LIMIT = 3;
    localparam int RUN_LEN    = 1 + SETTLE + (2 * N_CYC - 1) * HALF_P + TAIL;

    logic       clk;
    logic       i_rst_n;
    logic       i_start;
    logic       i_abort;
    logic       i_fwd_state;
    logic       i_neg_state;
    logic       i_fwd_bod;
    logic       i_neg_bod;
    logic       o_trig_fwd;
    logic       o_trig_neg;
    logic       o_forbid;
    logic       o_busy;
    logic       o_done;
    logic       o_pass;
    logic [7:0] o_fwd_fault;
    logic [7:0] o_neg_fault;
    logic [1:0] o_bod_seen;

    int n_checks;
    int n_pass;
    int cyc;

    int   done_cnt;
    int   done_rel;
    int   first_fwd;
    int   forbid_rel1;
    int   clr_fwd;
    int   clr_neg;
    int   width_err;
    int   space_err;
    int   overlap_cnt;
    int   rise_fwd_cnt;
    int   rise_neg_cnt;
    int   busy_after;
    int   fwd_after;
    int   pass_at;
    int   fwd_at;
    int   neg_at;
    int   bod_at;
    int   start_cyc;

    scr_test_sequencer #(
        .PULSE_W   (PULSE_W),
        .HALF_P    (HALF_P),
        .SETTLE    (SETTLE),
        .TAIL      (TAIL),
        .N_CYC     (N_CYC),
        .FAIL_LIMIT(FAIL_LIMIT)
    ) dut (
        .i_clk_50m  (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_fwd_state(i_fwd_state),
        .i_neg_state(i_neg_state),
        .i_fwd_bod  (i_fwd_bod),
        .i_neg_bod  (i_neg_bod),
        .o_trig_fwd (o_trig_fwd),
        .o_trig_neg (o_trig_neg),
        .o_forbid   (o_forbid),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_pass     (o_pass),
        .o_fwd_fault(o_fwd_fault),
        .o_neg_fault(o_neg_fault),
        .o_bod_seen (o_bod_seen)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One complete run; fst is flipped at run-relative cycle flip_at (never if negative)
    task automatic applyStimulus(input logic fst, input logic nst, input logic fbod,
                                 input logic nbod, input int flip_at, input bit hold_start);
        int   rel;
        int   last_rise;
        int   rise_f;
        int   rise_n;
        logic pf;
        logic pn;
        i_start     = 1'b0;
        i_fwd_state = fst;
        i_neg_state = nst;
        i_fwd_bod   = fbod;
        i_neg_bod   = nbod;
        repeat (2) @(negedge clk);
        done_cnt = 0; done_rel = -1; first_fwd = -1; forbid_rel1 = -1;
        clr_fwd = -1; clr_neg = -1; width_err = 0; space_err = 0; overlap_cnt = 0;
        rise_fwd_cnt = 0; rise_neg_cnt = 0;
        pass_at = -1; fwd_at = -1; neg_at = -1; bod_at = -1;
        last_rise = -1; rise_f = 0; rise_n = 0; pf = 1'b0; pn = 1'b0;
        start_cyc = cyc;
        i_start = 1'b1;
        for (int t = 1; t <= RUN_LEN + 8; t++) begin
            @(negedge clk);
            rel = cyc - start_cyc;
            if (!hold_start) i_start = 1'b0;
            if (rel == 1) forbid_rel1 = 32'(o_forbid);
            if (rel == 2) begin
                clr_fwd = 32'(o_fwd_fault);
                clr_neg = 32'(o_neg_fault);
            end
            if (rel == flip_at) i_fwd_state = ~fst;
            if (o_trig_fwd && o_trig_neg) overlap_cnt++;
            if (o_trig_fwd && !pf) begin
                rise_fwd_cnt++;
                if (first_fwd < 0) first_fwd = rel;
                if (last_rise >= 0 && rel - last_rise != HALF_P) space_err++;
                last_rise = rel;
                rise_f    = rel;
            end
            if (o_trig_neg && !pn) begin
                rise_neg_cnt++;
                if (last_rise >= 0 && rel - last_rise != HALF_P) space_err++;
                last_rise = rel;
                rise_n    = rel;
            end
            if (!o_trig_fwd && pf && (rel - rise_f != PULSE_W)) width_err++;
            if (!o_trig_neg && pn && (rel - rise_n != PULSE_W)) width_err++;
            if (o_done) begin
                done_cnt++;
                done_rel = rel;
                pass_at  = 32'(o_pass);
                fwd_at   = 32'(o_fwd_fault);
                neg_at   = 32'(o_neg_fault);
                bod_at   = 32'(o_bod_seen);
            end
            pf = o_trig_fwd;
            pn = o_trig_neg;
        end
        busy_after = 32'(o_busy);
        fwd_after  = 32'(o_fwd_fault);
        i_start    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_fwd_state = 1'b1; i_neg_state = 1'b1; i_fwd_bod = 1'b0; i_neg_bod = 1'b0;
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);

        checkOutput("rst_forbid", 32'(o_forbid), 1);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        checkOutput("rst_pass", 32'(o_pass), 0);
        checkOutput("rst_trig", 32'({o_trig_fwd, o_trig_neg}), 0);
        checkOutput("rst_counts", 32'({o_fwd_fault, o_neg_fault, 6'd0, o_bod_seen}), 0);

        // Healthy run with i_start held high from start through the end of the run
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b1);
        checkOutput("a_forbid_lat", forbid_rel1, 0);
        checkOutput("a_first_fwd", first_fwd, SETTLE + 1);
        checkOutput("a_done_cnt", done_cnt, 1);
        checkOutput("a_done_rel", done_rel, RUN_LEN);
        checkOutput("a_pass", pass_at, 1);
        checkOutput("a_fwd", fwd_at, 0);
        checkOutput("a_neg", neg_at, 0);
        checkOutput("a_bod", bod_at, 0);
        checkOutput("a_rise_fwd", rise_fwd_cnt, N_CYC);
        checkOutput("a_rise_neg", rise_neg_cnt, N_CYC);
        checkOutput("a_space_err", space_err, 0);
        checkOutput("a_width_err", width_err, 0);
        checkOutput("a_overlap", overlap_cnt, 0);
        checkOutput("a_no_restart", busy_after, 0);

        // Forward breakdown every pair plus forward BOD
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        checkOutput("b_done_cnt", done_cnt, 1);
        checkOutput("b_fwd", fwd_at, 4);
        checkOutput("b_neg", neg_at, 0);
        checkOutput("b_pass", pass_at, 0);
        checkOutput("b_bod", bod_at, 2);
        checkOutput("b_hold", fwd_after, 4);

        // Exactly three negative faults: final sample sees a healthy forward state
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 150, 1'b0);
        checkOutput("c_clear_fwd", clr_fwd, 0);
        checkOutput("c_clear_neg", clr_neg, 0);
        checkOutput("c_neg", neg_at, 3);
        checkOutput("c_fwd", fwd_at, 0);
        checkOutput("c_pass", pass_at, 1);
        checkOutput("c_bod", bod_at, 1);

        // Four negative faults, one over the limit
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        checkOutput("d_neg", neg_at, 4);
        checkOutput("d_pass", pass_at, 0);
        checkOutput("d_bod", bod_at, 0);

        // Abort during the pair-2 forward pulse
        i_fwd_state = 1'b1; i_neg_state = 1'b0; i_fwd_bod = 1'b0; i_neg_bod = 1'b0;
        repeat (2) @(negedge clk);
        start_cyc = cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (51) @(negedge clk);
        checkOutput("ab_rel", cyc - start_cyc, 52);
        checkOutput("ab_pre_fwd", 32'(o_fwd_fault), 1);
        checkOutput("ab_pre_trig", 32'(o_trig_fwd), 1);
        i_abort = 1'b1;
        @(negedge clk);
        checkOutput("ab_trig", 32'(o_trig_fwd), 0);
        checkOutput("ab_busy", 32'(o_busy), 0);
        checkOutput("ab_forbid", 32'(o_forbid), 1);
        checkOutput("ab_fwd", 32'(o_fwd_fault), 0);
        i_abort = 1'b0;
        i_neg_state = 1'b1;
        done_cnt = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_done) done_cnt++;
        end
        checkOutput("ab_no_done", done_cnt, 0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        checkOutput("e_done_cnt", done_cnt, 1);
        checkOutput("e_done_rel", done_rel, RUN_LEN);
        checkOutput("e_counts", fwd_at + neg_at, 0);
        checkOutput("e_pass", pass_at, 1);

        // Asynchronous reset during the pair-2 forward pulse
        i_neg_state = 1'b0;
        repeat (2) @(negedge clk);
        start_cyc = cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (51) @(negedge clk);
        checkOutput("rs_pre_fwd", 32'(o_fwd_fault), 1);
        checkOutput("rs_pre_trig", 32'(o_trig_fwd), 1);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("rs_trig", 32'(o_trig_fwd), 0);
        checkOutput("rs_forbid", 32'(o_forbid), 1);
        checkOutput("rs_busy", 32'(o_busy), 0);
        checkOutput("rs_counts", 32'({o_fwd_fault, o_neg_fault, 6'd0, o_bod_seen}), 0);
        i_neg_state = 1'b1;
        done_cnt = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (t == 3) i_rst_n = 1'b1;
            if (o_done) done_cnt++;
        end
        checkOutput("rs_no_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
